// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the data memory port: grant in IDLE, one-cycle access in ISSUE, registered readdata/rvalid next cycle.
// Macro DMEM_ARB_RR_EN selects round-robin arbitration; without it requester 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  output logic                     gnt0,
  output logic                     gnt1,
  input  logic [ADDRESS_WIDTH-1:0] a0,
  input  logic [ADDRESS_WIDTH-1:0] a1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [DATA_WIDTH-1:0]    writedata0,
  input  logic [DATA_WIDTH-1:0]    writedata1,
  input  logic [2:0]               memcontrol0,
  input  logic [2:0]               memcontrol1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    readdata0,
  output logic [DATA_WIDTH-1:0]    readdata1,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata,
  output logic                     busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state;
  logic   lat_id;
  logic   win1;
  logic   any_req;

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic ptr;
  // ptr=1 means requester 1 wins a tie
  assign win1 = req1 & (~req0 | ptr);
`else
  assign win1 = req1 & ~req0;
`endif

  assign gnt0 = (state == IDLE) & ~rst & req0 & ~win1;
  assign gnt1 = (state == IDLE) & ~rst & win1;
  assign busy = (state == ISSUE);

  // mem_we is a register cleared by the async reset, so a reset mid-ISSUE kills the write before the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lat_id         <= 1'b0;
      mem_a          <= '0;
      mem_we         <= 1'b0;
      mem_writedata  <= '0;
      mem_memcontrol <= 3'b010;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      readdata0      <= '0;
      readdata1      <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr            <= 1'b0;
`endif
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_id         <= win1;
            mem_a          <= win1 ? a1 : a0;
            mem_we         <= win1 ? we1 : we0;
            mem_writedata  <= win1 ? writedata1 : writedata0;
            mem_memcontrol <= win1 ? memcontrol1 : memcontrol0;
            state          <= ISSUE;
`ifdef DMEM_ARB_RR_EN
            ptr            <= ~win1;
`endif
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          if (lat_id) begin
            readdata1 <= mem_readdata;
            rvalid1   <= 1'b1;
          end else begin
            readdata0 <= mem_readdata;
            rvalid0   <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] writedata0 = '0, writedata1 = '0;
  logic [2:0]    memcontrol0 = 3'b010, memcontrol1 = 3'b010;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [DW-1:0] readdata0, readdata1, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_a;
  logic [2:0]    mem_memcontrol;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .a0(a0), .a1(a1), .we0(we0), .we1(we1),
    .writedata0(writedata0), .writedata1(writedata1),
    .memcontrol0(memcontrol0), .memcontrol1(memcontrol1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .readdata0(readdata0), .readdata1(readdata1),
    .mem_a(mem_a), .mem_we(mem_we), .mem_writedata(mem_writedata),
    .mem_memcontrol(mem_memcontrol), .mem_readdata(mem_readdata), .busy(busy)
  );

  // Memory fixture: combinational read, write on the edge; unwritten words hold a known pattern
  function automatic logic [DW-1:0] init_word(input logic [7:0] idx);
    return {24'hA5A5A5, idx};
  endfunction

  logic [DW-1:0] mem [0:255];
  logic [255:0]  written = '0;

  function automatic logic [DW-1:0] mem_rd(input logic [7:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  assign mem_readdata = mem_rd(mem_a[9:2]);

  initial forever begin
    @(posedge clk);
    if (mem_we) begin
      mem[mem_a[9:2]]     <= mem_writedata;
      written[mem_a[9:2]] <= 1'b1;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transactions scheduled as "access next cycle, result the cycle after"
  logic          m_iss, m_iss_id, m_iss_we, m_rv, m_rv_id, m_last, m_g0, m_g1;
  logic [AW-1:0] m_iss_a;
  logic [DW-1:0] m_iss_wd;
  logic [2:0]    m_iss_mc;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] shadow [0:255];
  logic [255:0]  sh_wr;

  initial begin
    sh_wr = '0;
    m_iss = 1'b0; m_rv = 1'b0; m_rv_id = 1'b0; m_last = 1'b1;
    m_iss_id = 1'b0; m_iss_we = 1'b0; m_iss_a = '0; m_iss_wd = '0; m_iss_mc = 3'b010;
    m_rd[0] = '0; m_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_iss = 1'b0; m_rv = 1'b0; m_last = 1'b1;
        m_rd[0] = '0; m_rd[1] = '0;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_readdata0", readdata0, '0);
        chk32("rst_readdata1", readdata1, '0);
        chk32("rst_mem_a", mem_a, '0);
        chk32("rst_mem_writedata", mem_writedata, '0);
        chk32("rst_mem_memcontrol", {29'd0, mem_memcontrol}, 32'd2);
      end else begin
        m_g0 = 1'b0; m_g1 = 1'b0;
        if (!m_iss) begin
          if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            if (m_last) m_g0 = 1'b1; else m_g1 = 1'b1;
`else
            m_g0 = 1'b1;
`endif
          end else begin
            m_g0 = req0;
            m_g1 = req1;
          end
        end
        chk1("m_gnt0", gnt0, m_g0);
        chk1("m_gnt1", gnt1, m_g1);
        chk1("m_busy", busy, m_iss);
        chk1("m_mem_we", mem_we, m_iss & m_iss_we);
        if (m_iss) begin
          chk32("m_mem_a", mem_a, m_iss_a);
          chk32("m_mem_writedata", mem_writedata, m_iss_wd);
          chk32("m_mem_memcontrol", {29'd0, mem_memcontrol}, {29'd0, m_iss_mc});
        end
        chk1("m_rvalid0", rvalid0, m_rv & ~m_rv_id);
        chk1("m_rvalid1", rvalid1, m_rv & m_rv_id);
        chk32("m_readdata0", readdata0, m_rd[0]);
        chk32("m_readdata1", readdata1, m_rd[1]);
        // advance one cycle
        m_rv = m_iss;
        if (m_iss) begin
          m_rv_id = m_iss_id;
          m_rd[m_iss_id] = sh_wr[m_iss_a[9:2]] ? shadow[m_iss_a[9:2]] : init_word(m_iss_a[9:2]);
          if (m_iss_we) begin
            shadow[m_iss_a[9:2]] = m_iss_wd;
            sh_wr[m_iss_a[9:2]]  = 1'b1;
          end
        end
        m_iss = m_g0 | m_g1;
        if (m_g0 | m_g1) begin
          m_iss_id = m_g1;
          m_last   = m_g1;
          m_iss_a  = m_g1 ? a1 : a0;
          m_iss_we = m_g1 ? we1 : we0;
          m_iss_wd = m_g1 ? writedata1 : writedata0;
          m_iss_mc = m_g1 ? memcontrol1 : memcontrol0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

`ifdef DMEM_ARB_RR_EN
  logic [8:0] e_g0 = 9'b000010001, e_g1 = 9'b001000100;
  logic [8:0] e_rv0 = 9'b001000100, e_rv1 = 9'b100010000;
`else
  logic [8:0] e_g0 = 9'b001010101, e_g1 = 9'b000000000;
  logic [8:0] e_rv0 = 9'b101010100, e_rv1 = 9'b000000000;
`endif
  logic [4:0] e_busy4 = 5'b00010;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cyc();

    // single load by requester 0
    req0 = 1'b1; a0 = 32'h0001_0000; we0 = 1'b0; memcontrol0 = 3'b010;
    #3 chk1("t1_gnt0", gnt0, 1'b1);
    chk1("t1_gnt1", gnt1, 1'b0);
    cyc(); req0 = 1'b0;
    #3 chk32("t1_mem_a", mem_a, 32'h0001_0000);
    chk1("t1_mem_we", mem_we, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    cyc();
    #3 chk1("t1_rvalid0", rvalid0, 1'b1);
    chk32("t1_readdata0", readdata0, 32'hA5A5A500);
    chk1("t1_rvalid1", rvalid1, 1'b0);

    // store then back-to-back load on requester 1
    cyc();
    req1 = 1'b1; a1 = 32'h0001_0004; we1 = 1'b1; writedata1 = 32'hCAFEF00D; memcontrol1 = 3'b010;
    #3 chk1("t2_gnt1", gnt1, 1'b1);
    chk1("t2_mem_we_idle", mem_we, 1'b0);
    cyc(); req1 = 1'b0;
    #3 chk1("t2_mem_we_issue", mem_we, 1'b1);
    chk32("t2_mem_writedata", mem_writedata, 32'hCAFEF00D);
    cyc();
    req1 = 1'b1; we1 = 1'b0;
    #3 chk1("t2_mem_we_after", mem_we, 1'b0);
    chk1("t2_store_ack", rvalid1, 1'b1);
    chk32("t2_store_rd", readdata1, 32'hA5A5A501);
    chk1("t2_regrant", gnt1, 1'b1);
    cyc(); req1 = 1'b0;
    cyc();
    #3 chk1("t2_load_rvalid1", rvalid1, 1'b1);
    chk32("t2_load_rd", readdata1, 32'hCAFEF00D);
    chk32("t2_rd0_hold", readdata0, 32'hA5A5A500);

    // both requesters held for 8 cycles
    cyc();
    req0 = 1'b1; req1 = 1'b1; a0 = 32'h0001_0000; we0 = 1'b0; a1 = 32'h0001_0004; we1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin req0 = 1'b0; req1 = 1'b0; end
      #3 chk1("t3_gnt0", gnt0, e_g0[i]);
      chk1("t3_gnt1", gnt1, e_g1[i]);
      chk1("t3_rvalid0", rvalid0, e_rv0[i]);
      chk1("t3_rvalid1", rvalid1, e_rv1[i]);
      cyc();
    end

    // requester 1 withdraws before being granted
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin req0 = 1'b0; req1 = 1'b0; end
      #3 chk1("t4_busy", busy, e_busy4[i]);
      chk1("t4_gnt1", gnt1, 1'b0);
      chk1("t4_rvalid1", rvalid1, 1'b0);
      cyc();
    end

    // reset in the middle of an ISSUE store
    req0 = 1'b1; a0 = 32'h0001_0008; we0 = 1'b1; writedata0 = 32'hDEADBEEF;
    #3 chk1("t5_gnt0", gnt0, 1'b1);
    cyc(); req0 = 1'b0;
    chk1("t5_mem_we_issue", mem_we, 1'b1);
    #1 rst = 1'b1;
    #1 chk1("t5_mem_we_async", mem_we, 1'b0);
    cyc();
    #1 rst = 1'b0;
    #2 chk1("t5_no_rvalid0", rvalid0, 1'b0);
    chk1("t5_idle", busy, 1'b0);
    chk32("t5_mem_unchanged", mem_rd(8'd2), 32'hA5A5A502);
    cyc();
    req0 = 1'b1; req1 = 1'b1; a0 = 32'h0001_0000; we0 = 1'b0; a1 = 32'h0001_0004; we1 = 1'b0;
    #3 chk1("t5_ptr0_gnt0", gnt0, 1'b1);
    chk1("t5_ptr0_gnt1", gnt1, 1'b0);
    cyc(); req0 = 1'b0;
    cyc();
    #3 chk1("t5_late_gnt1", gnt1, 1'b1);
    cyc(); req1 = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
